// File: rtl/seg_scan_pkg.sv
// Shared widths and bank types for the seven-segment scan controller.
package seg_scan_pkg;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;
    localparam int MAX_DIGITS = 8;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef digit_t [MAX_DIGITS-1:0] bank_t;
endpackage

// File: rtl/seg_scan_prescaler.sv
// Dwell prescaler: counts 0..DIV-1 and flags the last count of each dwell.
module seg_scan_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered digit scan controller driving a shared 7-seg decoder.
// Define SEG_SCAN_LZB_EN to build leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [3:0]   wr_data,
    input  logic         commit,
    output logic         commit_pend,
    output logic [2:0]   sel,
    output logic [3:0]   code,
    output logic         blank,
    output logic         frame_tick
);
    logic             tick;
    logic [SEL_W-1:0] idx_q, idx_d, idx_next;
    logic             idx_last, wrap, publish, wr_ok;
    logic             pend_q, pend_d;
    bank_t            shadow_q, active_q, src_bank;
    logic [SEL_W-1:0] sel_q;
    digit_t           code_q;
    logic             frame_tick_q;

    seg_scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        idx_last = (idx_q == SEL_W'(DIGITS - 1));
        wrap     = tick && idx_last;
        idx_next = idx_last ? '0 : idx_q + 1'b1;
        idx_d    = tick ? idx_next : idx_q;
        publish  = wrap && (pend_q || commit);
        pend_d   = publish ? 1'b0 : (pend_q || commit);
        wr_ok    = wr_en && ({1'b0, wr_addr} < 4'(DIGITS));
        // On a publishing wrap the outgoing digit must already reflect the new frame.
        src_bank = publish ? shadow_q : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            pend_q       <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            sel_q        <= '0;
            code_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            frame_tick_q <= wrap;
            if (wr_ok) begin
                shadow_q[wr_addr] <= wr_data;
            end
            if (publish) begin
                active_q <= shadow_q;
            end
            if (tick) begin
                sel_q  <= idx_next;
                code_q <= src_bank[idx_next];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic [MAX_DIGITS-1:0] upper_zero;
    logic                  blank_q;

    // upper_zero[i]: every digit from i to the most significant one is zero.
    for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_lz
        assign upper_zero[gi] = (src_bank[MAX_DIGITS-1:gi] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else if (tick) begin
            blank_q <= (idx_next != '0) && upper_zero[idx_next];
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign commit_pend = pend_q;
    assign sel         = sel_q;
    assign code        = code_q;
    assign frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=4, DIV=4.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       commit_pend;
    logic [2:0] sel;
    logic [3:0] code;
    logic       blank;
    logic       frame_tick;

    int e = 0;
    int checks = 0;
    int failures = 0;

    seg_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_pend (commit_pend),
        .sel         (sel),
        .code        (code),
        .blank       (blank),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic run_to(input int t);
        while (e < t) step();
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = d[3:0];
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks += 5;
        if (sel !== 3'd0)        begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        if (code !== 4'd0)       begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
        if (blank !== 1'b0)      begin failures++; $display("FAIL reset_blank got=%b exp=0", blank); end
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        if (commit_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", commit_pend); end
        rst_n = 1'b1;
        e = 0;
        $display("test_reset done");
    endtask

    task automatic test_scan();
        for (int i = 0; i < 32; i++) begin
            step();
            checks += 3;
            if (sel !== 3'((e / 4) % 4)) begin failures++; $display("FAIL scan_sel e=%0d got=%0d exp=%0d", e, sel, (e / 4) % 4); end
            if (code !== 4'd0) begin failures++; $display("FAIL scan_code e=%0d got=%0d exp=0", e, code); end
            if (frame_tick !== (e % 16 == 0)) begin failures++; $display("FAIL scan_frame_tick e=%0d got=%b", e, frame_tick); end
        end
        $display("test_scan done e=%0d", e);
    endtask

    task automatic test_write_commit();
        for (int a = 0; a < 4; a++) wr(a, a + 1);
        do_commit();
        checks++;
        if (commit_pend !== 1'b1) begin failures++; $display("FAIL wc_pend_rise got=%b exp=1", commit_pend); end
        run_to(47);
        checks++;
        if (commit_pend !== 1'b1) begin failures++; $display("FAIL wc_pend_hold got=%b exp=1", commit_pend); end
        step();
        checks += 2;
        if (commit_pend !== 1'b0) begin failures++; $display("FAIL wc_pend_fall got=%b exp=0", commit_pend); end
        if (frame_tick !== 1'b1)  begin failures++; $display("FAIL wc_frame_tick got=%b exp=1", frame_tick); end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            checks += 2;
            if (sel !== 3'((e / 4) % 4)) begin failures++; $display("FAIL wc_sel e=%0d got=%0d", e, sel); end
            if (code !== 4'((e / 4) % 4 + 1)) begin failures++; $display("FAIL wc_code e=%0d got=%0d exp=%0d", e, code, (e / 4) % 4 + 1); end
        end
        $display("test_write_commit done e=%0d", e);
    endtask

    task automatic test_no_commit();
        for (int a = 0; a < 4; a++) wr(a, a + 5);
        for (int i = 0; i < 48; i++) begin
            step();
            checks += 2;
            if (code !== 4'((e / 4) % 4 + 1)) begin failures++; $display("FAIL nc_code e=%0d got=%0d exp=%0d", e, code, (e / 4) % 4 + 1); end
            if (commit_pend !== 1'b0) begin failures++; $display("FAIL nc_pend e=%0d got=%b exp=0", e, commit_pend); end
        end
        $display("test_no_commit done e=%0d", e);
    endtask

    task automatic test_wrap_commit();
        run_to(127);
        commit  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'd9;
        step();
        commit  = 1'b0;
        wr_en   = 1'b0;
        checks += 3;
        if (commit_pend !== 1'b0) begin failures++; $display("FAIL wrc_pend got=%b exp=0", commit_pend); end
        if (code !== 4'd5)        begin failures++; $display("FAIL wrc_code0 got=%0d exp=5", code); end
        if (frame_tick !== 1'b1)  begin failures++; $display("FAIL wrc_frame_tick got=%b exp=1", frame_tick); end
        run_to(132);
        checks++;
        if (code !== 4'd6) begin failures++; $display("FAIL wrc_code1 got=%0d exp=6", code); end
        do_commit();
        run_to(144);
        checks += 2;
        if (code !== 4'd9)        begin failures++; $display("FAIL wrc_code_new got=%0d exp=9", code); end
        if (commit_pend !== 1'b0) begin failures++; $display("FAIL wrc_pend2 got=%b exp=0", commit_pend); end
        $display("test_wrap_commit done e=%0d", e);
    endtask

    task automatic test_bad_addr();
        logic [3:0] exp_code [4];
        exp_code[0] = 4'd9; exp_code[1] = 4'd6; exp_code[2] = 4'd7; exp_code[3] = 4'd8;
        wr(5, 15);
        wr(4, 14);
        do_commit();
        run_to(160);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            checks++;
            if (code !== exp_code[(e / 4) % 4]) begin failures++; $display("FAIL bad_addr_code e=%0d got=%0d exp=%0d", e, code, exp_code[(e / 4) % 4]); end
        end
        $display("test_bad_addr done e=%0d", e);
    endtask

    task automatic test_reset_mid();
        do_commit();
        run_to(185);
        checks++;
        if (sel !== 3'd2) begin failures++; $display("FAIL rm_pre_sel got=%0d exp=2", sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (sel !== 3'd0)         begin failures++; $display("FAIL rm_sel got=%0d exp=0", sel); end
        if (code !== 4'd0)        begin failures++; $display("FAIL rm_code got=%0d exp=0", code); end
        if (commit_pend !== 1'b0) begin failures++; $display("FAIL rm_pend got=%b exp=0", commit_pend); end
        if (frame_tick !== 1'b0)  begin failures++; $display("FAIL rm_frame_tick got=%b exp=0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (sel !== ((e < 4) ? 3'd0 : 3'd1)) begin failures++; $display("FAIL rm_dwell e=%0d got=%0d", e, sel); end
        end
        do_commit();
        run_to(16);
        checks++;
        if (code !== 4'd0) begin failures++; $display("FAIL rm_shadow_clear got=%0d exp=0", code); end
        $display("test_reset_mid done e=%0d", e);
    endtask

    task automatic test_blank();
        logic [3:0] exp_code [4];
        logic       exp_blank [4];
        exp_code[0] = 4'd0; exp_code[1] = 4'd7; exp_code[2] = 4'd0; exp_code[3] = 4'd0;
`ifdef SEG_SCAN_LZB_EN
        exp_blank[0] = 1'b0; exp_blank[1] = 1'b0; exp_blank[2] = 1'b1; exp_blank[3] = 1'b1;
`else
        exp_blank[0] = 1'b0; exp_blank[1] = 1'b0; exp_blank[2] = 1'b0; exp_blank[3] = 1'b0;
`endif
        wr(1, 7);
        do_commit();
        run_to(32);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            checks += 2;
            if (code !== exp_code[(e / 4) % 4]) begin failures++; $display("FAIL blank_code e=%0d got=%0d exp=%0d", e, code, exp_code[(e / 4) % 4]); end
            if (blank !== exp_blank[(e / 4) % 4]) begin failures++; $display("FAIL blank_bit e=%0d sel=%0d got=%b exp=%b", e, sel, blank, exp_blank[(e / 4) % 4]); end
        end
        $display("test_blank done e=%0d", e);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write_commit();
        test_no_commit();
        test_wrap_commit();
        test_bad_addr();
        test_reset_mid();
        test_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the shared seven-segment decoder (3-bit digit select + 4-bit BCD/hex code in, segment and digit-enable lines out). It holds up to eight digit values in a double-buffered register file and steps the decoder's select through the digits at a programmable refresh rate. It drives the decoder's `a`/`in`-style inputs so that one decoder instance serves every digit of the display. New values are written to a shadow bank and committed atomically at a frame boundary, so the display never shows a torn value.

## Interface
Parameters:
- DIGITS, 8: number of digits scanned, 1..8; the index wraps at DIGITS-1.
- DIV, 1000: clocks per digit dwell, ≥2.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for the shadow bank.
- wr_addr  in  3  shadow digit index; writes with wr_addr ≥ DIGITS are ignored.
- wr_data  in  4  digit code to write.
- commit  in  1  single-cycle request to publish the shadow bank to the active bank.
- commit_pend  out  1  high from the cycle after `commit` until the publishing wrap.
- sel  out  3  digit select to the decoder.
- code  out  4  digit code to the decoder.
- blank  out  1  high when the current digit is to be suppressed.
- frame_tick  out  1  one-cycle pulse on each index wrap.

## Operation
- The prescaler counts 0..DIV-1. `tick` is asserted when the count equals DIV-1; the count then wraps to 0.
- On tick, the index `idx` advances by 1. When `idx` = DIGITS-1, it wraps to 0, which defines a `wrap`.
- The shadow bank has DIGITS×4 bits. On wr_en, `shadow[wr_addr] <= wr_data` (addr in range only). wr_en never affects the active bank directly.
- `commit` sets `pend`. On a wrap with `pend`=1 (or with `commit`=1 in the same cycle):
  - `active <= shadow`, and `pend` clears.
  - The copy uses shadow contents *before* any same-cycle write.
  - A commit arriving in the wrap cycle is consumed by that wrap, and `pend` stays 0.
- Repeated commits while pending have no further effect.
- All outputs are registered.
  - On a tick edge, `sel <= next idx` and `code <= active[next idx]`.
  - On a publishing wrap, `code` takes `shadow[0]`, so digit 0 of the new frame shows the new value.
- `frame_tick` is high for the single cycle following the wrap edge.
- Reset mid-frame clears everything immediately. Scanning restarts at digit 0 with a full DIV dwell.
- Reset values: `sel`=0, `code`=0, `blank`=0, `frame_tick`=0, `commit_pend`=0. Internally, `idx`=0, prescaler=0, and both banks=0.

## Timing
- Dwell per digit is exactly DIV clocks. Frame period is DIGITS×DIV clocks.
- Write latency to display: the value appears at the first digit-0 dwell after the wrap that follows `commit`.
  - Worst case is DIGITS×DIV+1 clocks after `commit`.
- `commit_pend` rises 1 clock after `commit`. It falls on the same edge that loads `active`.
- DIGITS=1: every tick is a wrap, and `sel` stays 0.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking is compiled in. The highest index is the most significant digit.
  - `blank` is registered alongside `code`.
  - `blank`=1 for digit i ≠ 0 when active[j]=0 for all j ≥ i (post-commit values on a publishing wrap).
  - Digit 0 is never blanked.
- Not defined: `blank` is a constant 0 and no blanking logic is built.

## Structure
- Package `seg_scan_pkg` holds:
  - DIGIT_W=4, SEL_W=3, MAX_DIGITS=8.
  - The `digit_t` typedef (logic [3:0]) and the bank array typedef.
- One sub-module, `seg_scan_prescaler` (DIV parameter, outputs `tick`). It is instantiated once.
- The bank, index and commit logic stay in the top.

## Test plan
All scenarios use DIGITS=4, DIV=4 unless noted.
- Reset release, no writes: `sel` cycles 0,1,2,3,0 every 4 clocks. `code`=0 throughout. `frame_tick` pulses every 16 clocks.
- Write 1,2,3,4 to addr 0..3, then `commit`:
  - `commit_pend`=1 until the next wrap.
  - The following frame shows `code` 1,2,3,4 on `sel` 0..3.
- Writes without `commit`: the display is unchanged after 3 frames, and `commit_pend` stays 0.
- `commit` and wr_en(addr 0, value 9) in the wrap cycle: the frame publishes the old shadow[0]. The next commit+wrap shows 9.
- wr_addr=5 with DIGITS=4: ignored, and all shadow entries are unchanged after commit.
- With `SEG_SCAN_LZB_EN` and active = {3:0, 2:0, 1:7, 0:0}: `blank`=1 on `sel` 3 and 2, and 0 on `sel` 1 and 0.
- Reset asserted mid-dwell of `sel`=2: outputs are 0 immediately. After release, `sel`=0 holds for exactly 4 clocks.
